// File: rtl/m24c_pkg.sv
// Shared definitions for the M24Cxx transaction sequencer: state encoding,
// device-type code and the device-select byte builder.
package m24c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DSW,
    S_ADDR,
    S_DSR,
    S_RDB,
    S_WRB,
    S_STOP,
    S_POLL,
    S_FIN
  } state_t;

  localparam logic [3:0] DEV_TYPE       = 4'b1010;
  localparam int         PAGE_BYTES_DEF = 16;

  function automatic logic [7:0] devsel(input logic [2:0] chip, input logic rw);
    return {DEV_TYPE, chip, rw};
  endfunction

endpackage

// File: rtl/m24c_poll_ctr.sv
// Post-write ACK-poll retry counter: load with the retry budget, decrement
// per NACKed poll, expire flags that the current NACK is the last allowed.
module m24c_poll_ctr #(
  parameter int MAX = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(MAX);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt <= W'(1));

endmodule

// File: rtl/m24c_xfer_seq.sv
// Sequences one host read/write command into ordered I2C byte-engine
// operations, including the page-boundary check and post-write ACK polling.
module m24c_xfer_seq
  import m24c_pkg::*;
#(
  parameter int ACK_POLL_MAX = 255,
  parameter int PAGE_BYTES   = PAGE_BYTES_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [2:0] cmd_chip,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       eng_go,
  output logic [7:0] eng_byte,
  output logic       eng_read,
  output logic       eng_start,
  output logic       eng_ack,
  output logic       eng_stop,
  input  logic       eng_done,
  input  logic       eng_nack,
  input  logic [7:0] eng_rdata,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_t     state_q, state_d;
  logic       pend_q;
  logic       rdy_q;
  logic       error_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;

  logic       rw_q;
  logic [2:0] chip_q;
  logic [7:0] addr_q;
  logic [3:0] cnt_q;

  logic [7:0] byte_q;
  logic       read_q, start_q, ack_q, stop_q;

  logic [7:0] op_byte;
  logic       op_read, op_start, op_ack, op_stop, op_can;
  logic       accept, err_set, cnt_dec, poll_load, poll_dec, poll_expire;
  logic       op_done, reject;
  logic [8:0] page_end;

  assign page_end = 9'(cmd_addr & 8'(PAGE_BYTES - 1)) + 9'(cmd_len) + 9'd1;
  assign reject   = cmd_op && (page_end > 9'(PAGE_BYTES));
  assign op_done  = pend_q && eng_done;

  m24c_poll_ctr #(
    .MAX (ACK_POLL_MAX)
  ) u_poll_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (poll_load),
    .dec     (poll_dec),
    .expire  (poll_expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_byte   = 8'h00;
    op_read   = 1'b0;
    op_start  = 1'b0;
    op_ack    = 1'b0;
    op_stop   = 1'b0;
    op_can    = 1'b0;
    accept    = 1'b0;
    err_set   = 1'b0;
    cnt_dec   = 1'b0;
    poll_load = 1'b0;
    poll_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && rdy_q) begin
          accept  = 1'b1;
          state_d = reject ? S_FIN : S_DSW;
        end
      end
      S_DSW: begin
        op_byte  = devsel(chip_q, 1'b0);
        op_start = 1'b1;
        op_ack   = 1'b1;
        op_can   = 1'b1;
        if (op_done) begin
          state_d = eng_nack ? S_STOP : S_ADDR;
          err_set = eng_nack;
        end
      end
      S_ADDR: begin
        op_byte = addr_q;
        op_ack  = 1'b1;
        op_can  = 1'b1;
        if (op_done) begin
          state_d = eng_nack ? S_STOP : (rw_q ? S_WRB : S_DSR);
          err_set = eng_nack;
        end
      end
      S_DSR: begin
        op_byte  = devsel(chip_q, 1'b1);
        op_start = 1'b1;
        op_ack   = 1'b1;
        op_can   = 1'b1;
        if (op_done) begin
          state_d = eng_nack ? S_STOP : S_RDB;
          err_set = eng_nack;
        end
      end
      S_RDB: begin
        // Master ACKs every byte but the last, which is NACKed and closed with stop
        op_read = 1'b1;
        op_ack  = (cnt_q != 4'd0);
        op_stop = (cnt_q == 4'd0);
        op_can  = 1'b1;
        if (op_done) begin
          if (cnt_q == 4'd0) state_d = S_FIN;
          else               cnt_dec = 1'b1;
        end
      end
      S_WRB: begin
        op_byte = wr_data;
        op_ack  = 1'b1;
        op_stop = (cnt_q == 4'd0);
        op_can  = wr_valid;
        if (op_done) begin
          if (eng_nack) begin
            state_d = S_STOP;
            err_set = 1'b1;
          end else if (cnt_q == 4'd0) begin
            state_d   = S_POLL;
            poll_load = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      S_STOP: begin
        op_stop = 1'b1;
        op_can  = 1'b1;
        if (op_done) state_d = S_FIN;
      end
      S_POLL: begin
        op_byte  = devsel(chip_q, 1'b0);
        op_start = 1'b1;
        op_ack   = 1'b1;
        op_stop  = 1'b1;
        op_can   = 1'b1;
        if (op_done) begin
          if (!eng_nack) begin
            state_d = S_FIN;
          end else if (poll_expire) begin
            state_d = S_FIN;
            err_set = 1'b1;
          end else begin
            poll_dec = 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      rdy_q      <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      rdy_q      <= 1'b1;
      rd_valid_q <= op_done && (state_q == S_RDB);
      if (op_done && (state_q == S_RDB)) rd_data_q <= eng_rdata;
      if (eng_go)       pend_q <= 1'b1;
      else if (op_done) pend_q <= 1'b0;
      if (accept)       error_q <= reject;
      else if (err_set) error_q <= 1'b1;
    end
  end

  // Command fields and the in-flight operation are data; they need no reset
  always_ff @(posedge clock) begin
    if (accept) begin
      rw_q   <= cmd_op;
      chip_q <= cmd_chip;
      addr_q <= cmd_addr;
      cnt_q  <= cmd_len;
    end else if (cnt_dec) begin
      cnt_q <= cnt_q - 4'd1;
    end
    if (eng_go) begin
      byte_q  <= op_byte;
      read_q  <= op_read;
      start_q <= op_start;
      ack_q   <= op_ack;
      stop_q  <= op_stop;
    end
  end

  // Controls come from the live decode on the go cycle, then from the held copy
  assign eng_go    = op_can && !pend_q;
  assign eng_byte  = pend_q ? byte_q  : op_byte;
  assign eng_read  = pend_q ? read_q  : op_read;
  assign eng_start = pend_q ? start_q : op_start;
  assign eng_ack   = pend_q ? ack_q   : op_ack;
  assign eng_stop  = pend_q ? stop_q  : op_stop;

  assign wr_ready  = eng_go && (state_q == S_WRB);
  assign cmd_ready = rdy_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign error     = error_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_m24c_xfer_seq.sv
// Randomized bench for m24c_xfer_seq: byte-engine model plus a queue-based
// reference of the expected operation list, read bytes and status.
module tb_m24c_xfer_seq;

  localparam int POLL_MAX = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [2:0] cmd_chip;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       eng_go, eng_read, eng_start, eng_ack, eng_stop;
  logic [7:0] eng_byte;
  logic       eng_done, eng_nack;
  logic [7:0] eng_rdata;
  logic       busy, done, error;

  always #5 clock = ~clock;

  m24c_xfer_seq #(.ACK_POLL_MAX(POLL_MAX), .PAGE_BYTES(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_chip(cmd_chip), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .eng_go(eng_go), .eng_byte(eng_byte), .eng_read(eng_read),
    .eng_start(eng_start), .eng_ack(eng_ack), .eng_stop(eng_stop),
    .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata),
    .busy(busy), .done(done), .error(error)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Engine policy and observations; op word = {start, read, ack, stop, byte}
  int         nack_idx = -1, poll_nacks = 0, rd_served = 0, poll_seen = 0, op_idx = 0;
  logic [7:0] rd_base = 8'h00;
  bit         spur = 1'b0;
  logic [7:0] wq[$];
  logic [7:0] wdat[$];
  int         cyc = 0, eng_pend = 0, eng_wait = 0, viol = 0, rd_timing_err = 0;
  int         acc_cyc = -1, first_go_cyc = -1, last_edone_cyc = -1, last_rdone_cyc = -1;
  int         done_cyc = -1, got_wr = 0;
  bit         got_done = 1'b0, done_err = 1'b0;
  logic [11:0] cur_op = 12'h0;
  logic [11:0] got_ops[$];
  logic [7:0]  got_rd[$];

  always begin
    @(negedge clock);
    cyc++;
    eng_done  = 1'b0;
    eng_nack  = 1'b0;
    eng_rdata = 8'h00;
    if (!reset_n) eng_pend = 0;
    if (spur) begin
      eng_done = 1'b1;
      eng_nack = 1'b1;
      spur     = 1'b0;
    end else if (eng_pend != 0) begin
      if (eng_wait == 0) begin
        eng_done = 1'b1;
        if (cur_op[10]) begin
          eng_rdata = 8'(int'(rd_base) + rd_served);
          rd_served++;
          last_rdone_cyc = cyc;
        end else if (cur_op[11] && cur_op[8]) begin
          eng_nack = (poll_seen < poll_nacks);
          poll_seen++;
        end else begin
          eng_nack = ((op_idx - 1) == nack_idx);
        end
        eng_pend = 0;
        last_edone_cyc = cyc;
      end else begin
        eng_wait--;
      end
    end
    wr_valid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
    wr_data  = wr_valid ? wq[0] : 8'($urandom);
    #1;
    if (reset_n) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (eng_go) begin
        if (eng_pend != 0) viol++;
        cur_op = {eng_start, eng_read, eng_ack, eng_stop, eng_byte};
        got_ops.push_back(cur_op);
        op_idx++;
        if (first_go_cyc < 0) first_go_cyc = cyc;
        eng_pend = 1;
        eng_wait = $urandom_range(0, 3);
      end else if ((eng_pend != 0) && ({eng_start, eng_read, eng_ack, eng_stop, eng_byte} != cur_op)) begin
        viol++;
      end
      if (wr_ready) begin
        if (!wr_valid) viol++;
        got_wr++;
        if (wq.size() > 0) void'(wq.pop_front());
      end
      if (rd_valid) begin
        got_rd.push_back(rd_data);
        if (cyc != last_rdone_cyc + 1) rd_timing_err++;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        done_err = error;
      end
    end
  end

  // Reference: what the command should produce on the bus and to the host
  logic [11:0] exp_ops[$];
  logic [7:0]  exp_rd[$];
  int          exp_wr;
  bit          exp_err;

  function automatic bit push_op(input logic [11:0] o, input int nidx);
    exp_ops.push_back(o);
    return (exp_ops.size() - 1) == nidx;
  endfunction

  task automatic build_exp(input bit op, input logic [2:0] chip, input logic [7:0] addr,
                           input logic [3:0] len, input int nidx, input int pn, input logic [7:0] base);
    int n;
    logic [7:0] ds0, ds1;
    n   = int'(len) + 1;
    ds0 = {4'b1010, chip, 1'b0};
    ds1 = {4'b1010, chip, 1'b1};
    exp_ops.delete();
    exp_rd.delete();
    exp_wr  = 0;
    exp_err = 1'b0;
    if (op && ((int'(addr) % 16) + n > 16)) begin
      exp_err = 1'b1;
      return;
    end
    if (push_op({4'b1010, ds0}, nidx) || push_op({4'b0010, addr}, nidx)) begin
      exp_ops.push_back(12'h100);
      exp_err = 1'b1;
      return;
    end
    if (!op) begin
      if (push_op({4'b1010, ds1}, nidx)) begin
        exp_ops.push_back(12'h100);
        exp_err = 1'b1;
        return;
      end
      for (int i = 0; i < n; i++) begin
        void'(push_op({1'b0, 1'b1, (i != n - 1), (i == n - 1), 8'h00}, -1));
        exp_rd.push_back(8'(int'(base) + i));
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_wr++;
        if (push_op({2'b00, 1'b1, (i == n - 1), wdat[i]}, nidx)) begin
          exp_ops.push_back(12'h100);
          exp_err = 1'b1;
          return;
        end
      end
      for (int p = 0; p < POLL_MAX; p++) begin
        void'(push_op({4'b1011, ds0}, -1));
        if (p >= pn) return;
      end
      exp_err = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_rdv"}, 32'(rd_valid), 0);
    chk({tag, "_wrr"}, 32'(wr_ready), 0);
    chk({tag, "_go"}, 32'(eng_go), 0);
    chk({tag, "_ctl"}, 32'({eng_read, eng_start, eng_ack, eng_stop}), 0);
    chk({tag, "_byte"}, 32'(eng_byte), 0);
    chk({tag, "_rdata"}, 32'(rd_data), 0);
  endtask

  task automatic run_cmd(input string tag, input bit op, input logic [2:0] chip, input logic [7:0] addr,
                         input logic [3:0] len, input int nidx, input int pn, input bit rst_mid);
    int k;
    logic [7:0] base;
    base = 8'($urandom);
    if (tag == "plan_rd" || tag == "after_rst" || tag == "rst_rd") base = 8'hA0;
    build_exp(op, chip, addr, len, nidx, pn, base);
    k = 0;
    @(negedge clock);
    #2;
    while (!cmd_ready && k < 50) begin
      @(negedge clock);
      #2;
      k++;
    end
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    @(negedge clock);
    nack_idx = nidx; poll_nacks = pn; rd_base = base;
    rd_served = 0; poll_seen = 0; op_idx = 0; viol = 0; rd_timing_err = 0;
    got_ops.delete(); got_rd.delete(); got_wr = 0; got_done = 1'b0;
    first_go_cyc = -1; acc_cyc = -1;
    wq = wdat;
    cmd_valid = 1'b1; cmd_op = op; cmd_chip = chip; cmd_addr = addr; cmd_len = len;
    @(negedge clock);
    cmd_valid = 1'b0;
    if (rst_mid) begin
      k = 0;
      while (op_idx < 5 && k < 500) begin
        @(negedge clock);
        #2;
        k++;
      end
      chk({tag, "_reach_byte2"}, 32'(op_idx), 5);
      #2 reset_n = 1'b0;
      #1 check_reset_values({tag, "_mid"});
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      return;
    end
    for (k = 0; k < 3000 && !got_done; k++) @(negedge clock);
    #2;
    chk({tag, "_timeout"}, 32'(got_done), 1);
    chk({tag, "_accepted"}, 32'(acc_cyc >= 0), 1);
    chk({tag, "_nops"}, 32'(got_ops.size()), 32'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++)
      chk($sformatf("%s_op%0d", tag, i), 32'(got_ops[i]), 32'(exp_ops[i]));
    chk({tag, "_nrd"}, 32'(got_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i), 32'(got_rd[i]), 32'(exp_rd[i]));
    chk({tag, "_wr_pulses"}, 32'(got_wr), 32'(exp_wr));
    chk({tag, "_error"}, 32'(done_err), 32'(exp_err));
    chk({tag, "_stable"}, 32'(viol), 0);
    chk({tag, "_rd_timing"}, 32'(rd_timing_err), 0);
    if (exp_ops.size() == 0) begin
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(acc_cyc + 1));
    end else begin
      chk({tag, "_first_go"}, 32'(first_go_cyc), 32'(acc_cyc + 1));
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(last_edone_cyc + 1));
    end
    @(negedge clock);
    #2;
    chk({tag, "_err_held"}, 32'(error), 32'(exp_err));
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_chip = 3'd0; cmd_addr = 8'h00; cmd_len = 4'd0;
    repeat (3) @(negedge clock);
    #1 check_reset_values("rst");
    @(negedge clock);
    reset_n = 1'b1;

    wdat.delete();
    run_cmd("plan_rd", 1'b0, 3'b001, 8'h20, 4'd3, -1, 0, 1'b0);

    wdat = '{8'h11, 8'h12, 8'h13, 8'h14};
    run_cmd("plan_wr", 1'b1, 3'b000, 8'h1C, 4'd3, -1, 2, 1'b0);
    run_cmd("page_x", 1'b1, 3'b010, 8'h1E, 4'd3, -1, 0, 1'b0);
    run_cmd("wr_addr_nack", 1'b1, 3'b011, 8'h40, 4'd3, 1, 0, 1'b0);
    wdat.delete();
    run_cmd("rd_addr_nack", 1'b0, 3'b101, 8'h30, 4'd2, 1, 0, 1'b0);
    wdat = '{8'h5A, 8'hC3};
    run_cmd("poll_max", 1'b1, 3'b111, 8'h00, 4'd1, -1, 100, 1'b0);

    wdat.delete();
    run_cmd("rst_rd", 1'b0, 3'b001, 8'h20, 4'd3, -1, 0, 1'b1);
    run_cmd("after_rst", 1'b0, 3'b001, 8'h20, 4'd3, -1, 0, 1'b0);

    // Stray engine completion while idle must be ignored
    got_ops.delete();
    @(negedge clock);
    spur = 1'b1;
    repeat (4) @(negedge clock);
    #2;
    chk("spur_busy", 32'(busy), 0);
    chk("spur_ops", 32'(got_ops.size()), 0);
    chk("spur_ready", 32'(cmd_ready), 1);

    for (int r = 0; r < 14; r++) begin
      bit         op;
      logic [3:0] len;
      int         nidx;
      op   = 1'($urandom);
      len  = 4'($urandom);
      nidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      wdat.delete();
      for (int i = 0; i <= int'(len); i++) wdat.push_back(8'($urandom));
      run_cmd($sformatf("rnd%0d", r), op, 3'($urandom), 8'($urandom), len, nidx,
              $urandom_range(0, 5), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
